sbox_subbytes_seq: RTL

SBOX_SUBBYTES_SEQ -- requirements
Module: sbox_subbytes_seq

---
 rtl/sbox_subbytes_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sbox_subbytes_seq.sv
// Sequential AES SubBytes: one shared S-box, one byte per RUN cycle, 16 cycles per block.
// Optional macro SBOX_SHUFFLE_EN randomises the byte processing order via an LFSR-chosen start offset.

module AES_Sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  // Ascending range so the leftmost byte of the literal is entry 0.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y_o = SBOX[a_i];
endmodule

module sbox_subbytes_seq #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   k_q, k_d;
  logic [3:0]   idx;
  logic [127:0] data_q, res_q;
  logic [7:0]   sbox_in, sbox_out;
  logic         accept;

  if (LFSR_SEED == 8'h00) begin : g_seed_chk
    $error("LFSR_SEED must be nonzero");
  end

  assign accept = (state_q == IDLE) && in_valid;

`ifdef SBOX_SHUFFLE_EN
  logic [7:0] lfsr_q;
  logic [3:0] off_q;

  // x^8+x^6+x^5+x^4+1, free-running in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      off_q  <= 4'd0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (accept) off_q <= lfsr_q[3:0];
    end
  end

  assign idx = off_q + k_q;
`else
  assign idx = k_q;
`endif

  assign sbox_in = data_q[8*idx +: 8];

  AES_Sbox u_sbox (
    .a_i (sbox_in),
    .y_o (sbox_out)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        k_d     = 4'd0;
      end
      RUN: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; in_ready is masked by rst so nothing can be accepted during reset.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    out_data  = out_valid ? res_q : 128'd0;
  end

  // Input snapshot and per-byte result write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 128'd0;
      res_q  <= 128'd0;
    end else begin
      if (accept) data_q <= in_data;
      if (state_q == RUN) res_q[8*idx +: 8] <= sbox_out;
    end
  end
endmodule
